// File: rtl/seq_pkg.sv
// Shared definitions for the sequence datapath (playback and verifier sides).
//   SEQ_LEN / NUM_W / SEQ_W : sequence geometry (5 entries of 4 bits)
//   disp_state_t            : playback FSM states
//   clamp_lvl()             : maps a raw level to 1..SEQ_LEN
//   entry_of()              : selects entry idx from a packed sequence
package seq_pkg;

   localparam int unsigned SEQ_LEN = 5;
   localparam int unsigned NUM_W   = 4;
   localparam int unsigned SEQ_W   = SEQ_LEN * NUM_W;
   localparam int unsigned LVL_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP,
      DONE
   } disp_state_t;

   // Level 0 still plays one entry; anything past the sequence length plays all of it.
   function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
      logic [LVL_W-1:0] r;
      r = lvl;
      if (lvl == '0) begin
         r = LVL_W'(1);
      end else if (lvl > LVL_W'(SEQ_LEN)) begin
         r = LVL_W'(SEQ_LEN);
      end
      return r;
   endfunction

   // Out-of-range indices yield 0 rather than reading past the sequence.
   function automatic logic [NUM_W-1:0] entry_of(input logic [SEQ_W-1:0] seq,
                                                 input logic [LVL_W-1:0] idx);
      logic [NUM_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
         if (idx == LVL_W'(i)) begin
            r = seq[i*NUM_W +: NUM_W];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_display_timer.sv
// Loadable down-counter used for the show / blank intervals.
//   clk      : system clock
//   rst      : synchronous active-low reset (count cleared)
//   load     : load load_val this cycle (has priority over en)
//   load_val : value to load
//   en       : decrement while non-zero
//   zero     : count is zero
module seq_display_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/seq_display.sv
// Plays the stored game sequence: shows the first LVL entries one at a time,
// each for ON_CYCLES clocks followed by OFF_CYCLES blank clocks, then holds
// display_done until the next accepted start.
//   clk          : system clock
//   rst          : synchronous active-low reset
//   start        : one-cycle play request, ignored while busy
//   LVL          : entries to play (clamped to 1..5)
//   Sequence     : packed entries, entry 0 in the low nibble plays first
//   disp_num     : entry being shown, 0 while blank
//   disp_valid   : disp_num holds a valid entry
//   busy         : playback in progress
//   display_done : playback finished (level)
module seq_display
   import seq_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = 50_000_000,
   parameter int unsigned OFF_CYCLES = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LVL_W-1:0] LVL,
   input  logic [SEQ_W-1:0] Sequence,
   output logic [NUM_W-1:0] disp_num,
   output logic             disp_valid,
   output logic             busy,
   output logic             display_done
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);
   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

   disp_state_t      state_q, state_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic [LVL_W-1:0] idx_q, idx_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_en;
   logic             tmr_zero;
   logic [LVL_W-1:0] idx_inc;

   seq_display_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   assign idx_inc = idx_q + LVL_W'(1);

   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      lvl_d    = lvl_q;
      idx_d    = idx_q;
      num_d    = num_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = done_q;
      tmr_load = 1'b0;
      tmr_val  = ON_LOAD;
      tmr_en   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               seq_d    = Sequence;
               lvl_d    = clamp_lvl(LVL);
               idx_d    = '0;
               num_d    = entry_of(Sequence, '0);
               valid_d  = 1'b1;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = ON_LOAD;
               state_d  = SHOW;
            end
         end
         SHOW: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               num_d    = '0;
               valid_d  = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = OFF_LOAD;
               state_d  = GAP;
            end
         end
         GAP: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               // Widen by one bit so idx+1 cannot wrap before the compare.
               if (({1'b0, idx_q} + 4'd1) < {1'b0, lvl_q}) begin
                  idx_d    = idx_inc;
                  num_d    = entry_of(seq_q, idx_inc);
                  valid_d  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = ON_LOAD;
                  state_d  = SHOW;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         seq_q   <= '0;
         lvl_q   <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         lvl_q   <= lvl_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign disp_num     = num_q;
   assign disp_valid   = valid_q;
   assign busy         = busy_q;
   assign display_done = done_q;

endmodule

// File: tb/tb_seq_display.sv
module tb_seq_display;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = ON + OFF;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  LVL;
   logic [19:0] Sequence;
   logic [3:0]  disp_num;
   logic        disp_valid;
   logic        busy;
   logic        display_done;

   int vectors = 0;
   int errors  = 0;

   seq_display #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .LVL          (LVL),
      .Sequence     (Sequence),
      .disp_num     (disp_num),
      .disp_valid   (disp_valid),
      .busy         (busy),
      .display_done (display_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a playback is described only by the cycle of its first
   // visible entry plus the latched sequence and level; every output follows
   // from the elapsed time since then.
   int          cyc   = 0;
   int          first = -1;
   logic [19:0] m_seq = '0;
   int          m_lvl = 1;

   function automatic bit m_busy(int c);
      return (first >= 0) && (c >= first) && ((c - first) < m_lvl * PER);
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst === 1'b0) begin
         first = -1;
      end else if (start === 1'b1 && !m_busy(cyc - 1)) begin
         first = cyc;
         m_seq = Sequence;
         m_lvl = (LVL == 0) ? 1 : ((LVL > 5) ? 5 : int'(LVL));
      end
   end

   // {disp_num, disp_valid, busy, display_done}
   function automatic logic [6:0] model_out(int c);
      int d, slot, ph;
      logic [3:0] e;
      if (first < 0) return 7'd0;
      d = c - first;
      if (d >= m_lvl * PER) return {4'd0, 1'b0, 1'b0, 1'b1};
      slot = d / PER;
      ph   = d % PER;
      e    = 4'((m_seq >> (4 * slot)) & 20'hF);
      if (ph < ON) return {e, 1'b1, 1'b1, 1'b0};
      return {4'd0, 1'b0, 1'b1, 1'b0};
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== 7'd0) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%h exp=00", cyc, {disp_num, disp_valid, busy, display_done});
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [3:0] exp_num [1:16] = '{8,8,8,0,0,1,1,1,0,0,2,2,2,0,0,0};
      Sequence = 20'h84218; LVL = 3'd3; start = 1'b1;
      for (int rel = 1; rel <= 18; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL basic rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel <= 16) begin
            vectors++;
            if (disp_num !== exp_num[rel] || display_done !== (rel == 16)) begin
               errors++;
               $display("FAIL basic_table rel=%0d num=%0d done=%b exp_num=%0d exp_done=%b",
                        rel, disp_num, display_done, exp_num[rel], rel == 16);
            end
         end
         if (rel == 1) start = 1'b0;
      end
   endtask

   task automatic test_lvl_clamp();
      Sequence = 20'h84218; LVL = 3'd0; start = 1'b1;
      for (int rel = 1; rel <= 8; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL lvl0 rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 5 || rel == 6) begin
            vectors++;
            if (display_done !== (rel == 6)) begin
               errors++;
               $display("FAIL lvl0_done rel=%0d got=%b exp=%b", rel, display_done, rel == 6);
            end
         end
         if (rel == 1) start = 1'b0;
      end
      LVL = 3'd7; start = 1'b1;
      for (int rel = 1; rel <= 28; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL lvl7 rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 25 || rel == 26) begin
            vectors++;
            if (display_done !== (rel == 26)) begin
               errors++;
               $display("FAIL lvl7_done rel=%0d got=%b exp=%b", rel, display_done, rel == 26);
            end
         end
         if (rel == 1) start = 1'b0;
      end
   endtask

   task automatic test_repeat();
      Sequence = 20'h11111; LVL = 3'd2; start = 1'b1;
      for (int rel = 1; rel <= 12; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL repeat rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 4 || rel == 6) begin
            vectors++;
            if (disp_valid !== (rel == 6)) begin
               errors++;
               $display("FAIL repeat_gap rel=%0d got=%b exp=%b", rel, disp_valid, rel == 6);
            end
         end
         if (rel == 1) start = 1'b0;
      end
   endtask

   task automatic test_busy_ignore();
      Sequence = 20'h84218; LVL = 3'd3; start = 1'b1;
      for (int rel = 1; rel <= 18; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL busy_ign rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 11 || rel == 16) begin
            vectors++;
            if ((rel == 11 && disp_num !== 4'd2) || (rel == 16 && display_done !== 1'b1)) begin
               errors++;
               $display("FAIL busy_ign_fixed rel=%0d num=%0d done=%b", rel, disp_num, display_done);
            end
         end
         if (rel == 1) start = 1'b0;
         if (rel == 2) Sequence = 20'hFEDCB;
         if (rel == 5) start = 1'b1;
         if (rel == 6) start = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      Sequence = 20'h84218; LVL = 3'd3; start = 1'b1;
      for (int rel = 1; rel <= 9; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL rst_mid rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 8) begin
            vectors++;
            if ({disp_num, disp_valid, busy, display_done} !== 7'd0) begin
               errors++;
               $display("FAIL rst_mid_zero got=%h exp=00", {disp_num, disp_valid, busy, display_done});
            end
         end
         if (rel == 1) start = 1'b0;
         if (rel == 7) rst = 1'b0;
         if (rel == 8) rst = 1'b1;
      end
      Sequence = 20'h00035; LVL = 3'd2; start = 1'b1;
      for (int rel = 1; rel <= 12; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL rst_replay rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 1) begin
            start = 1'b0;
            vectors++;
            if (disp_num !== 4'd5) begin
               errors++;
               $display("FAIL rst_replay_first got=%0d exp=5", disp_num);
            end
         end
      end
   endtask

   task automatic test_restart_done();
      LVL = 3'd1; Sequence = 20'h0000C; start = 1'b1;
      for (int rel = 1; rel <= 7; rel++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL restart rel=%0d got=%h exp=%h", rel, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         if (rel == 1 || rel == 5 || rel == 6) begin
            vectors++;
            if (display_done !== (rel == 6)) begin
               errors++;
               $display("FAIL restart_done rel=%0d got=%b exp=%b", rel, display_done, rel == 6);
            end
         end
         if (rel == 1) start = 1'b0;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         vectors++;
         if ({disp_num, disp_valid, busy, display_done} !== model_out(cyc)) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {disp_num, disp_valid, busy, display_done}, model_out(cyc));
         end
         start    = ($urandom_range(0, 7) == 0);
         LVL      = 3'($urandom);
         Sequence = 20'($urandom);
         rst      = ($urandom_range(0, 99) != 0);
      end
      rst = 1'b1; start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; LVL = '0; Sequence = '0;
      test_reset();
      test_basic();
      test_lvl_clamp();
      test_repeat();
      test_busy_ignore();
      test_reset_mid();
      test_restart_done();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
